// File: rtl/program_loader.sv
// Host-side run controller: streams a program into instruction memory with the CPU held
// in reset, then releases it, pulses cpu_start and times the run until done or cycle limit.
module program_loader #(
  parameter int          ADDR_W     = 10,
  parameter int          INSTR_W    = 9,
  parameter int          CYC_W      = 32,
  parameter int unsigned MAX_CYCLES = 32'd1048576
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               go,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               ack,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic [INSTR_W-1:0] s_data,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_waddr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               cpu_start,
  input  logic               cpu_done,
  output logic               busy,
  output logic               run_done,
  output logic               timeout,
  output logic               len_err,
  output logic [CYC_W-1:0]   cycle_count
);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LOAD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_START   = 3'd3,
    ST_RUN     = 3'd4,
    ST_FINISH  = 3'd5
  } state_t;

  localparam logic [ADDR_W:0]  DEPTH     = (ADDR_W+1)'(1) << ADDR_W;
  localparam logic [CYC_W-1:0] CYC_LIMIT = CYC_W'(MAX_CYCLES);

  state_t state_q, state_d;

  logic [ADDR_W:0]    len_q, len_d;
  logic [ADDR_W:0]    cnt_q, cnt_d;
  logic               s_ready_q, s_ready_d;
  logic               imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]  imem_waddr_q, imem_waddr_d;
  logic [INSTR_W-1:0] imem_wdata_q, imem_wdata_d;
  logic               cpu_reset_q, cpu_reset_d;
  logic               cpu_start_q, cpu_start_d;
  logic               busy_q, busy_d;
  logic               run_done_q, run_done_d;
  logic               timeout_q, timeout_d;
  logic               len_err_q, len_err_d;
  logic [CYC_W-1:0]   cycle_count_q, cycle_count_d;

  logic               hs;
  logic               go_ok;
  logic               last_word;
  logic [CYC_W-1:0]   cyc_inc;
  logic               limit_hit;

  // s_ready is only ever high in LOAD, so a handshake implies the LOAD state.
  assign hs        = s_valid & s_ready_q;
  assign go_ok     = go & (prog_len != '0) & (prog_len <= DEPTH);
  assign last_word = ((cnt_q + (ADDR_W+1)'(1)) == len_q);
  assign cyc_inc   = cycle_count_q + CYC_W'(1);
  assign limit_hit = (cyc_inc == CYC_LIMIT);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (go_ok) state_d = ST_LOAD; else state_d = ST_IDLE;
      ST_LOAD:    if (hs && last_word) state_d = ST_RELEASE; else state_d = ST_LOAD;
      ST_RELEASE: state_d = ST_START;
      ST_START:   state_d = ST_RUN;
      ST_RUN: begin
        if (cpu_done) begin
          state_d = ST_FINISH;
        end else if (limit_hit) begin
          state_d = ST_FINISH;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_FINISH:  if (ack) state_d = ST_IDLE; else state_d = ST_FINISH;
      default:    state_d = ST_IDLE;
    endcase
  end

  // Output and datapath next values; flags follow the state being entered
  always_comb begin
    s_ready_d     = (state_d == ST_LOAD);
    cpu_reset_d   = (state_d == ST_IDLE) || (state_d == ST_LOAD) || (state_d == ST_RELEASE);
    cpu_start_d   = (state_d == ST_START);
    busy_d        = (state_d != ST_IDLE);
    run_done_d    = (state_d == ST_FINISH);
    len_err_d     = (state_q == ST_IDLE) && go && !go_ok;
    imem_we_d     = 1'b0;
    imem_waddr_d  = imem_waddr_q;
    imem_wdata_d  = imem_wdata_q;
    len_d         = len_q;
    cnt_d         = cnt_q;
    timeout_d     = timeout_q;
    cycle_count_d = cycle_count_q;
    case (state_q)
      ST_IDLE: begin
        if (go_ok) begin
          len_d         = prog_len;
          cnt_d         = '0;
          timeout_d     = 1'b0;
          cycle_count_d = '0;
        end else begin
          len_d         = len_q;
        end
      end
      ST_LOAD: begin
        if (hs) begin
          imem_we_d    = 1'b1;
          imem_waddr_d = cnt_q[ADDR_W-1:0];
          imem_wdata_d = s_data;
          cnt_d        = cnt_q + (ADDR_W+1)'(1);
        end else begin
          imem_we_d    = 1'b0;
        end
      end
      ST_RELEASE: cycle_count_d = '0;
      ST_RUN: begin
        // A done on the limit edge takes priority and leaves timeout clear.
        if (cpu_done) begin
          cycle_count_d = cycle_count_q;
        end else if (limit_hit) begin
          cycle_count_d = CYC_LIMIT;
          timeout_d     = 1'b1;
        end else begin
          cycle_count_d = cyc_inc;
        end
      end
      default: cnt_d = cnt_q;
    endcase
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      len_q         <= '0;
      cnt_q         <= '0;
      s_ready_q     <= 1'b0;
      imem_we_q     <= 1'b0;
      imem_waddr_q  <= '0;
      imem_wdata_q  <= '0;
      cpu_reset_q   <= 1'b1;
      cpu_start_q   <= 1'b0;
      busy_q        <= 1'b0;
      run_done_q    <= 1'b0;
      timeout_q     <= 1'b0;
      len_err_q     <= 1'b0;
      cycle_count_q <= '0;
    end else begin
      len_q         <= len_d;
      cnt_q         <= cnt_d;
      s_ready_q     <= s_ready_d;
      imem_we_q     <= imem_we_d;
      imem_waddr_q  <= imem_waddr_d;
      imem_wdata_q  <= imem_wdata_d;
      cpu_reset_q   <= cpu_reset_d;
      cpu_start_q   <= cpu_start_d;
      busy_q        <= busy_d;
      run_done_q    <= run_done_d;
      timeout_q     <= timeout_d;
      len_err_q     <= len_err_d;
      cycle_count_q <= cycle_count_d;
    end
  end

  assign s_ready     = s_ready_q;
  assign imem_we     = imem_we_q;
  assign imem_waddr  = imem_waddr_q;
  assign imem_wdata  = imem_wdata_q;
  assign cpu_reset   = cpu_reset_q;
  assign cpu_start   = cpu_start_q;
  assign busy        = busy_q;
  assign run_done    = run_done_q;
  assign timeout     = timeout_q;
  assign len_err     = len_err_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_program_loader.sv
// Randomized directed bench for program_loader: a host/CPU model drives load and run
// phases and an instruction-memory array plus a cycle model check every outcome.
module tb_program_loader;
  localparam int AW   = 10;
  localparam int IW   = 9;
  localparam int CW   = 32;
  localparam int MAXC = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          go = 1'b0;
  logic [AW:0]   prog_len = '0;
  logic          ack = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [IW-1:0] s_data = '0;
  logic          imem_we;
  logic [AW-1:0] imem_waddr;
  logic [IW-1:0] imem_wdata;
  logic          cpu_reset;
  logic          cpu_start;
  logic          cpu_done = 1'b0;
  logic          busy;
  logic          run_done;
  logic          timeout;
  logic          len_err;
  logic [CW-1:0] cycle_count;

  program_loader #(.ADDR_W(AW), .INSTR_W(IW), .CYC_W(CW), .MAX_CYCLES(MAXC)) dut (
    .clk(clk), .reset(reset), .go(go), .prog_len(prog_len), .ack(ack),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .cpu_reset(cpu_reset), .cpu_start(cpu_start), .cpu_done(cpu_done),
    .busy(busy), .run_done(run_done), .timeout(timeout), .len_err(len_err),
    .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            wcnt  = 0;
  logic [IW-1:0] words   [1024];
  logic [IW-1:0] mem_act [1024];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: a handshake seen before the edge must appear as a write after it.
  task automatic tick();
    logic          hs;
    logic [IW-1:0] hd;
    hs = (s_valid === 1'b1) && (s_ready === 1'b1) && (reset === 1'b1);
    hd = s_data;
    @(posedge clk);
    #1;
    chk("imem_we", 64'(imem_we), 64'(hs));
    if (hs) begin
      chk("imem_waddr", 64'(imem_waddr), 64'(wcnt));
      chk("imem_wdata", 64'(imem_wdata), 64'(hd));
      wcnt++;
    end
    if (imem_we === 1'b1) mem_act[imem_waddr] = imem_wdata;
  endtask

  task automatic check_reset_vals();
    chk("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_imem_we", 64'(imem_we), 64'd0);
    chk("rst_cpu_start", 64'(cpu_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_run_done", 64'(run_done), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_len_err", 64'(len_err), 64'd0);
    chk("rst_waddr", 64'(imem_waddr), 64'd0);
    chk("rst_wdata", 64'(imem_wdata), 64'd0);
    chk("rst_cycle_count", 64'(cycle_count), 64'd0);
  endtask

  // Full load+run; dly = RUN edges with cpu_done low before it rises (<0: never).
  task automatic do_run(input int len, input int gap_max, input bit gap4, input int dly);
    int idx, budget, gapcnt, n;
    bit hs_now, fin, exp_to;
    prog_len = 11'(len);
    go = 1'b1;
    wcnt = 0;
    tick();
    go = 1'b0;
    chk("go_busy", 64'(busy), 64'd1);
    chk("go_s_ready", 64'(s_ready), 64'd1);
    chk("go_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("go_len_err", 64'(len_err), 64'd0);
    chk("go_cycle_count", 64'(cycle_count), 64'd0);
    idx = 0; budget = 0; gapcnt = 0;
    while (idx < len && budget < 5000) begin
      chk("load_s_ready", 64'(s_ready), 64'd1);
      s_valid = (gap_max == 0) ? 1'b1 : ($urandom_range(0, gap_max) == 0);
      if (gap4 && idx == 2 && gapcnt < 4) begin
        s_valid = 1'b0;
        gapcnt++;
      end
      s_data = words[idx];
      hs_now = s_valid && (s_ready === 1'b1);
      tick();
      if (hs_now) idx++;
      chk("load_cpu_reset", 64'(cpu_reset), 64'd1);
      chk("load_cpu_start", 64'(cpu_start), 64'd0);
      budget++;
    end
    chk("load_words_accepted", 64'(idx), 64'(len));
    chk("rel_s_ready", 64'(s_ready), 64'd0);
    chk("rel_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("rel_cpu_start", 64'(cpu_start), 64'd0);
    s_valid = 1'($urandom);
    s_data = 9'($urandom);
    tick();
    chk("start_pulse", 64'(cpu_start), 64'd1);
    chk("start_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("start_cycle_count", 64'(cycle_count), 64'd0);
    chk("start_s_ready", 64'(s_ready), 64'd0);
    cpu_done = 1'($urandom);
    tick();
    chk("run_cpu_start", 64'(cpu_start), 64'd0);
    chk("run_cpu_reset", 64'(cpu_reset), 64'd0);
    chk("run_run_done", 64'(run_done), 64'd0);
    chk("run_cycle_count0", 64'(cycle_count), 64'd0);
    n = 0; fin = 1'b0; exp_to = 1'b0;
    while (!fin && n <= MAXC + 2) begin
      cpu_done = (dly >= 0) && (n >= dly);
      go = 1'($urandom);
      prog_len = 11'($urandom);
      ack = 1'($urandom);
      tick();
      if (cpu_done) fin = 1'b1;
      else if (n + 1 == MAXC) begin n = MAXC; exp_to = 1'b1; fin = 1'b1; end
      else n++;
      chk("run_len_err", 64'(len_err), 64'd0);
      chk("run_busy", 64'(busy), 64'd1);
      chk("run_fin", 64'(run_done), 64'(fin));
      chk("run_cycle_count", 64'(cycle_count), 64'(n));
    end
    go = 1'b1; ack = 1'b0; cpu_done = 1'b1;
    chk("fin_timeout", 64'(timeout), 64'(exp_to));
    chk("fin_cpu_reset", 64'(cpu_reset), 64'd0);
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("hold_run_done", 64'(run_done), 64'd1);
      chk("hold_cycle_count", 64'(cycle_count), 64'(n));
      chk("hold_timeout", 64'(timeout), 64'(exp_to));
      chk("hold_busy", 64'(busy), 64'd1);
    end
    go = 1'b0; ack = 1'b1;
    tick();
    ack = 1'b0; cpu_done = 1'b0; s_valid = 1'b0;
    chk("ack_busy", 64'(busy), 64'd0);
    chk("ack_run_done", 64'(run_done), 64'd0);
    chk("ack_cpu_reset", 64'(cpu_reset), 64'd1);
    chk("ack_s_ready", 64'(s_ready), 64'd0);
    for (int i = 0; i < len; i++) chk("mem_contents", 64'(mem_act[i]), 64'(words[i]));
  endtask

  task automatic bad_len(input logic [AW:0] l);
    prog_len = l;
    go = 1'b1;
    tick();
    go = 1'b0;
    chk("len_err_pulse", 64'(len_err), 64'd1);
    chk("len_err_busy", 64'(busy), 64'd0);
    chk("len_err_s_ready", 64'(s_ready), 64'd0);
    tick();
    chk("len_err_clear", 64'(len_err), 64'd0);
    chk("len_err_busy2", 64'(busy), 64'd0);
  endtask

  initial begin
    int idx, budget;
    bit hs_now;
    repeat (3) @(posedge clk);
    #1;
    check_reset_vals();
    reset = 1'b1;
    tick();

    // Directed three-word program, streaming, done after 10 RUN cycles
    words[0] = 9'h1A5; words[1] = 9'h000; words[2] = 9'h1C0;
    do_run(3, 0, 1'b0, 10);

    // Backpressure gap, then timeout with cpu_done held low
    for (int i = 0; i < 5; i++) words[i] = 9'($urandom);
    do_run(5, 0, 1'b1, -1);

    // cpu_done rises on the limit edge
    for (int i = 0; i < 40; i++) words[i] = 9'($urandom);
    do_run($urandom_range(1, 40), 3, 1'b0, MAXC - 1);

    bad_len(11'd0);
    bad_len(11'd1025);
    bad_len(11'd2047);

    // Reset mid-load after two accepted words
    for (int i = 0; i < 5; i++) words[i] = 9'($urandom);
    prog_len = 11'd5; go = 1'b1; wcnt = 0;
    tick();
    go = 1'b0;
    idx = 0; budget = 0;
    while (idx < 2 && budget < 100) begin
      s_valid = 1'($urandom);
      s_data = words[idx];
      hs_now = s_valid && (s_ready === 1'b1);
      tick();
      if (hs_now) idx++;
      budget++;
    end
    chk("partial_words", 64'(idx), 64'd2);
    s_valid = 1'b1;
    s_data = words[idx];
    #2 reset = 1'b0;
    #1;
    check_reset_vals();
    for (int k = 0; k < 2; k++) begin
      tick();
      chk("rst_hold_busy", 64'(busy), 64'd0);
    end
    reset = 1'b1;
    s_valid = 1'b0;
    tick();
    check_reset_vals();
    do_run(5, 2, 1'b0, $urandom_range(0, 20));

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 24; i++) words[i] = 9'($urandom);
      do_run($urandom_range(1, 24), $urandom_range(0, 3), 1'b0, $urandom_range(0, 21) - 1);
    end

    // Largest legal program
    for (int i = 0; i < 1024; i++) words[i] = 9'($urandom);
    do_run(1024, 0, 1'b0, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/program_loader.md
# program_loader

Host-facing run controller that sits directly upstream of the CPU top level. It accepts a program as a valid/ready stream of 9-bit instruction words and writes them into instruction memory, holding the CPU in reset while it does so. It then releases reset, pulses `cpu_start`, and times the run until the CPU raises `done` or a cycle limit expires. It reports busy, completion, timeout and the cycle count to the host.

## Interface
Parameters:
- `ADDR_W`, 10, instruction memory address width; depth is 2^ADDR_W.
- `INSTR_W`, 9, instruction word width.
- `CYC_W`, 32, cycle counter width.
- `MAX_CYCLES`, 2^20, run-cycle limit; must be ≤ 2^CYC_W−1.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `go`  in  1  host request; sampled only in IDLE.
- `prog_len`  in  ADDR_W+1  number of words to load; sampled with `go`.
- `ack`  in  1  host acknowledge; returns FINISH to IDLE.
- `s_valid`  in  1  program word valid.
- `s_ready`  out  1  loader can accept a word.
- `s_data`  in  INSTR_W  program word.
- `imem_we`  out  1  instruction memory write enable.
- `imem_waddr`  out  ADDR_W  write address.
- `imem_wdata`  out  INSTR_W  write data.
- `cpu_reset`  out  1  active-high reset to the CPU.
- `cpu_start`  out  1  one-cycle start pulse to the CPU.
- `cpu_done`  in  1  CPU halt indication (level).
- `busy`  out  1  high in any state other than IDLE.
- `run_done`  out  1  high in FINISH.
- `timeout`  out  1  run ended by the cycle limit; valid in FINISH.
- `len_err`  out  1  one-cycle pulse on a rejected `go`.
- `cycle_count`  out  CYC_W  run length in cycles.

## Operation
- States: IDLE, LOAD, RELEASE, START, RUN, FINISH. Encoding is free.
- IDLE: `cpu_reset`=1, `s_ready`=0.
  - `go` with 1 ≤ `prog_len` ≤ 2^ADDR_W: latch `prog_len`, clear the word counter, `timeout` and `cycle_count`, then go to LOAD.
  - `go` with `prog_len`=0 or `prog_len` > 2^ADDR_W: pulse `len_err` for one cycle and stay in IDLE.
- LOAD: `s_ready`=1 and `cpu_reset`=1.
  - Each handshake (`s_valid`&&`s_ready`) registers `imem_we`=1, `imem_waddr`=word counter, `imem_wdata`=`s_data` for the following cycle, then increments the counter.
  - `imem_we`=0 in every cycle that has no preceding handshake.
  - When the accepted word is number `prog_len`: go to RELEASE, and `s_ready` drops in the next cycle.
  - Words arrive in address order from 0. The counter never wraps because the length is checked in IDLE.
- RELEASE: `cpu_reset`=1 for this one cycle, so the final write lands while the CPU is still held in reset. Next state is START.
- START: `cpu_reset`=0, `cpu_start`=1 for exactly one cycle, `cycle_count`=0. `cpu_done` is ignored in this cycle. Next state is RUN.
- RUN: `cpu_reset`=0.
  - Each edge with `cpu_done`=0: increment `cycle_count`.
  - `cpu_done`=1: go to FINISH without incrementing.
  - If the increment would make `cycle_count` equal `MAX_CYCLES`: store `MAX_CYCLES`, set `timeout`=1, go to FINISH.
  - If `cpu_done` and the limit occur on the same edge, `cpu_done` wins and `timeout`=0.
- FINISH: `run_done`=1 and `cpu_reset`=0, so the CPU stays halted and its data memory can be inspected. `cycle_count` and `timeout` hold. `ack` returns to IDLE.
- `go` outside IDLE is ignored. `ack` outside FINISH is ignored.
- On return to IDLE, `cpu_reset` reasserts, which clears the CPU's done latch. Instruction memory contents are kept.

## Timing
- Reset (`reset`=0, asynchronous) forces:
  - state IDLE, `cpu_reset`=1;
  - `s_ready`, `imem_we`, `cpu_start`, `busy`, `run_done`, `timeout`, `len_err`=0;
  - `imem_waddr`, `imem_wdata`, `cycle_count`=0.
- Reset asserted mid-LOAD or mid-RUN aborts immediately, with no further writes. The partial program remains in memory.
- `go` high at edge E: `busy`=1 and `s_ready`=1 from cycle E+1.
- Handshake at edge H: the write is presented on the `imem_*` outputs during cycle H+1.
- Last handshake at edge H: RELEASE in H+1, `cpu_start` in H+2, RUN from H+3.
- All outputs are registered.
- `cycle_count` = number of RUN-state edges at which `cpu_done` was low.

## Test plan
- Load 3 words (0x1A5, 0x000, 0x1C0) with `s_valid` held high: writes to addresses 0,1,2 on consecutive cycles, `cpu_start` pulses once 2 cycles after the last write, and `cpu_reset`=1 throughout the load.
- Backpressure: gap of 4 idle cycles between words 1 and 2 → `imem_we` is 0 during the gap, addresses remain contiguous, and no word is lost or duplicated.
- Full run: `cpu_done` rises 10 cycles after entering RUN → `run_done`=1, `cycle_count`=10, `timeout`=0; `ack` returns to IDLE with `cpu_reset`=1.
- Timeout with `MAX_CYCLES`=16 and `cpu_done` held low → FINISH, `timeout`=1, `cycle_count`=16. A further case with `cpu_done` rising on the limit edge → `timeout`=0.
- `go` with `prog_len`=0, then with `prog_len`=1025 → one-cycle `len_err` each time and `busy` stays 0. `go` during RUN → no effect.
- Assert `reset` after 2 of 5 words are accepted → immediate IDLE with reset values. A fresh `go` then reloads from address 0.
